// File: rtl/twos_to_signmag_serial.sv
// Bit-serial two's-complement to sign-magnitude converter.
// One operand bit per clock, LSB first, using copy-through-first-1 then invert.
module twos_to_signmag_serial #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_sign,
   output logic [WIDTH-1:0] out_mag,
   output logic             busy
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t           state;
   logic [WIDTH-1:0] operand;
   logic [WIDTH-1:0] result;
   logic [CW-1:0]    cnt;
   logic             sign;
   logic             seen_one;

   logic             res_bit;
   logic [WIDTH-1:0] result_nxt;

   // Negative operands pass bits through up to and including the first 1,
   // then invert the rest; positive operands pass through unchanged.
   always_comb begin
      res_bit    = sign ? (operand[0] ^ seen_one) : operand[0];
      result_nxt = {res_bit, result[WIDTH-1:1]};
   end

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign busy      = (state == SHIFT);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         operand  <= '0;
         result   <= '0;
         cnt      <= '0;
         sign     <= 1'b0;
         seen_one <= 1'b0;
         out_sign <= 1'b0;
         out_mag  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  operand  <= in_data;
                  sign     <= in_data[WIDTH-1];
                  seen_one <= 1'b0;
                  cnt      <= '0;
                  state    <= SHIFT;
               end
            end
            SHIFT: begin
               operand  <= operand >> 1;
               result   <= result_nxt;
               seen_one <= seen_one | operand[0];
               if (cnt == LAST) begin
                  out_mag  <= result_nxt;
                  out_sign <= sign;
                  cnt      <= '0;
                  state    <= DONE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            DONE: begin
               // Handshake edge only returns to IDLE; a new accept needs another edge.
               if (out_ready) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_twos_to_signmag_serial.sv
// Directed bench for twos_to_signmag_serial: driver queues expected results,
// a negedge monitor compares whenever the DUT presents a result.
module tb_twos_to_signmag_serial;

   localparam int WIDTH = 8;

   typedef struct packed {
      logic             s;
      logic [WIDTH-1:0] m;
   } exp_t;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [WIDTH-1:0] in_data = '0;
   logic             out_valid;
   logic             out_ready = 1'b1;
   logic             out_sign;
   logic [WIDTH-1:0] out_mag;
   logic             busy;

   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;
   int   acc_cyc = 0;
   exp_t q[$];
   exp_t last = '0;
   logic prev_valid = 1'b0;
   logic after_hs = 1'b0;

   twos_to_signmag_serial #(.WIDTH(WIDTH)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
      .out_sign(out_sign), .out_mag(out_mag), .busy(busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   // Monitor
   always @(negedge clk) begin
      if (rst_n) begin
         if (out_valid) begin
            if (!prev_valid) chk("latency", 32'(cyc - acc_cyc), WIDTH);
            if (q.size() == 0) begin
               chk("spurious_out_valid", 1, 0);
            end else begin
               chk("out_sign", 32'(out_sign), 32'(q[0].s));
               chk("out_mag", 32'(out_mag), 32'(q[0].m));
               chk("in_ready_in_done", 32'(in_ready), 0);
               chk("busy_in_done", 32'(busy), 0);
               if (out_ready) begin
                  last = q.pop_front();
                  after_hs = 1'b1;
               end
            end
         end else if (after_hs) begin
            chk("in_ready_after_hs", 32'(in_ready), 1);
            after_hs = 1'b0;
         end
         if (busy) chk("mag_retained", 32'({out_sign, out_mag}), 32'(last));
         prev_valid = out_valid;
      end else begin
         prev_valid = 1'b0;
      end
   end

   task automatic wait_ready();
      int n = 0;
      while (!in_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) chk("in_ready_timeout", 0, 1);
   endtask

   task automatic send(input logic [WIDTH-1:0] d, input logic push,
                       input logic s, input logic [WIDTH-1:0] m);
      wait_ready();
      in_valid = 1'b1;
      in_data  = d;
      if (push) q.push_back(exp_t'{s: s, m: m});
      @(negedge clk);
      acc_cyc  = cyc;
      in_valid = 1'b0;
      in_data  = 8'hA5;  // garbage after accept must not matter
   endtask

   task automatic drain();
      int n = 0;
      while ((q.size() != 0 || !in_ready) && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (q.size() != 0) chk("drain_timeout", 32'(q.size()), 0);
   endtask

   initial begin
      #1;
      chk("rst_in_ready", 32'(in_ready), 1);
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_out", 32'({out_sign, out_mag}), 0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      send(8'h05, 1'b1, 1'b0, 8'h05);
      send(8'hFB, 1'b1, 1'b1, 8'h05);
      send(8'h80, 1'b1, 1'b1, 8'h80);
      send(8'hFF, 1'b1, 1'b1, 8'h01);
      send(8'h00, 1'b1, 1'b0, 8'h00);
      drain();

      // Stall the consumer for 5 cycles on 0xC8 (-56).
      out_ready = 1'b0;
      send(8'hC8, 1'b1, 1'b1, 8'h38);
      begin
         int n = 0;
         while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
         end
         if (!out_valid) chk("c8_valid_timeout", 0, 1);
      end
      repeat (5) @(negedge clk);
      chk("c8_still_valid", 32'(out_valid), 1);
      out_ready = 1'b1;
      drain();

      // Abandon 0x9C mid-shift with an async reset.
      send(8'h9C, 1'b0, 1'b0, 8'h00);
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      #1;
      last = '0;
      chk("midrst_out", 32'({out_sign, out_mag}), 0);
      chk("midrst_busy", 32'(busy), 0);
      chk("midrst_in_ready", 32'(in_ready), 1);
      chk("midrst_out_valid", 32'(out_valid), 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("postrst_in_ready", 32'(in_ready), 1);
      chk("postrst_out_valid", 32'(out_valid), 0);

      send(8'h7F, 1'b1, 1'b0, 8'h7F);
      drain();
      repeat (3) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/twos_to_signmag_serial.md
TWOS_TO_SIGNMAG_SERIAL -- requirements
Module: twos_to_signmag_serial

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand width in bits; legal range is WIDTH >= 2.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port in_valid, input, 1 bit: in_data is valid.
REQ-005 The block SHALL have port in_ready, output, 1 bit: the block can accept an operand.
REQ-006 The block SHALL have port in_data, input, WIDTH bits: two's-complement operand.
REQ-007 The block SHALL have port out_valid, output, 1 bit: the result is valid.
REQ-008 The block SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-009 The block SHALL have port out_sign, output, 1 bit: sign of the operand; 1 means negative.
REQ-010 The block SHALL have port out_mag, output, WIDTH bits: unsigned magnitude of the operand.
REQ-011 The block SHALL have port busy, output, 1 bit: high in the SHIFT state.

Function
REQ-012 The block SHALL implement a three-state FSM with states IDLE, SHIFT and DONE.
REQ-013 in_ready SHALL equal (state == IDLE).
REQ-014 out_valid SHALL equal (state == DONE).
REQ-015 busy SHALL equal (state == SHIFT).
REQ-016 Accept: in IDLE, when in_valid=1 at a rising edge, the block SHALL do all of the following on that edge:
  - register in_data into an operand shift register;
  - set sign to in_data[WIDTH-1];
  - clear the seen_one flag;
  - clear the bit counter;
  - enter SHIFT.
REQ-017 In SHIFT, each edge SHALL process one operand bit, LSB first, and shift the result bit into an internal result register, MSB-insert/right-shift.
REQ-018 Per-bit rule for sign=0: result bit = operand bit.
REQ-019 Per-bit rule for sign=1: result bit = operand bit XOR seen_one, evaluated before the update; then seen_one = seen_one OR operand bit. This is copy-through-first-1, invert-thereafter.
REQ-020 The bit counter SHALL count 0..WIDTH-1. On the edge processing bit WIDTH-1, the block SHALL do all of the following:
  - load out_mag from the completed result;
  - load out_sign from sign;
  - reset the counter to 0;
  - enter DONE.
REQ-021 Latency: out_valid SHALL rise exactly WIDTH rising edges after the accepting edge.
REQ-022 In DONE, out_sign and out_mag SHALL be held stable until out_valid=1 and out_ready=1 at a rising edge; the block then SHALL return to IDLE.
REQ-023 Throughput SHALL be one result per WIDTH+2 cycles minimum. No accept is permitted in DONE, even on the handshake edge.
REQ-024 in_valid and in_data SHALL be ignored outside IDLE. in_data SHALL NOT be sampled after the accepting edge.
REQ-025 out_ready SHALL be ignored outside DONE.
REQ-026 out_mag and out_sign SHALL retain the previous result in IDLE and SHIFT, and SHALL change only on the SHIFT->DONE edge.
REQ-027 Boundary, most-negative input (only MSB set): out_sign=1, out_mag = 2^(WIDTH-1); no overflow flag.
REQ-028 Boundary, zero input: out_sign=0, out_mag=0.
REQ-029 Boundary, all-ones input: out_sign=1, out_mag=1.
REQ-030 The bit counter SHALL be ceil(log2(WIDTH)) bits wide and SHALL never wrap past WIDTH-1.

Reset
REQ-031 While rst_n=0, the block SHALL asynchronously force all of the following:
  - state=IDLE;
  - out_valid=0, busy=0;
  - out_sign=0, out_mag=0;
  - counter=0, seen_one=0;
  - operand and result registers = 0.
REQ-032 During reset, in_ready SHALL read 1, and no handshake SHALL be accepted.
REQ-033 Reset asserted mid-SHIFT or in DONE SHALL abandon the operation: no result is presented, and the first edge after deassertion is in IDLE.
REQ-034 Reset deassertion SHALL be synchronous to clk in the surrounding system; the block adds no synchronizer.

Verification
REQ-035 The bench SHALL cover the following directed scenarios, with WIDTH=8:
  - in_data=0x05 -> out_valid after 8 edges, out_sign=0, out_mag=0x05.
  - in_data=0xFB -> out_sign=1, out_mag=0x05.
  - in_data=0x80 -> out_sign=1, out_mag=0x80; in_data=0xFF -> out_sign=1, out_mag=0x01.
  - in_data=0x00 -> out_sign=0, out_mag=0x00.
  - in_data=0xC8 with out_ready=0 for 5 cycles:
    - out_valid held, out_sign=1, out_mag=0x38 stable, in_ready=0;
    - after the handshake, in_ready=1 next cycle.
  - rst_n pulsed low at the 4th SHIFT edge of 0x9C -> outputs zero, IDLE; then 0x7F -> out_sign=0, out_mag=0x7F.
